// File: rtl/bp_pkg.sv
// Shared types for the branch-prediction slice: the in-flight prediction record
// that fetch hands to execute, and the 2-bit saturating counter used by the PHT.
package bp_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } pred_entry_t;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_MAX = 2'b11;
    localparam cnt_t CNT_MIN = 2'b00;

    // Saturating step of a 2-bit counter toward the observed outcome.
    function automatic cnt_t cnt_update(input cnt_t cnt, input logic taken);
        cnt_t next_cnt;
        next_cnt = cnt;
        if (taken && (cnt != CNT_MAX)) begin
            next_cnt = cnt + 2'b01;
        end else if (!taken && (cnt != CNT_MIN)) begin
            next_cnt = cnt - 2'b01;
        end
        return next_cnt;
    endfunction

endpackage

// File: rtl/pht.sv
// Pattern history table: 2**PHT_BITS two-bit saturating counters.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset (counters -> RESET_CNT)
//   rd_idx_i        lookup index (asynchronous read)
//   rd_cnt_o        counter at rd_idx_i; old value when rd_idx_i == upd_idx_i
//   upd_en_i        train the counter at upd_idx_i at the next clock edge
//   upd_idx_i       training index
//   upd_taken_i     training direction (1: increment, 0: decrement)
module pht
    import bp_pkg::*;
#(
    parameter int   PHT_BITS  = 6,
    parameter cnt_t RESET_CNT = 2'b01
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [PHT_BITS-1:0] rd_idx_i,
    output cnt_t                rd_cnt_o,
    input  logic                upd_en_i,
    input  logic [PHT_BITS-1:0] upd_idx_i,
    input  logic                upd_taken_i
);

    localparam int ENTRIES = 2 ** PHT_BITS;

    cnt_t cnt_q [ENTRIES];

    // NOTE: the counters are architectural prediction state that must restart
    // from a known value, so this array is reset; pure data storage whose
    // contents are qualified by separate valid/occupancy state is not.
    // NOTE: sequential state is written with <= so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= RESET_CNT;
            end
        end else if (upd_en_i) begin
            cnt_q[upd_idx_i] <= cnt_update(cnt_q[upd_idx_i], upd_taken_i);
        end
    end

    // No write-to-read bypass: a same-cycle lookup sees the pre-update value.
    assign rd_cnt_o = cnt_q[rd_idx_i];

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver. Holds fetch's predictions in an in-order
// queue, resolves the oldest one against the actual outcome, raises a one-cycle
// registered mispredict with the redirect PC on a mismatch (flushing the queue),
// and trains the PHT that fetch reads.
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   pred_valid_i/pc/taken/target   prediction push from fetch
//   pred_ready_o                   push accepted when valid && ready
//   lookup_pc_i, lookup_taken_o    combinational PHT lookup for fetch
//   res_valid_i/is_branch/taken/target  resolve of the oldest queued entry
//   mispredict_o, redirect_pc_o    registered redirect pulse and target
//   res_error_o                    sticky: resolve arrived with an empty queue
//   occupancy_o                    number of queued predictions
module branch_resolver
    import bp_pkg::*;
#(
    parameter int   PHT_BITS    = 6,
    parameter int   QUEUE_DEPTH = 4,
    parameter cnt_t RESET_CNT   = 2'b01
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         pred_valid_i,
    input  logic [31:0]                  pred_pc_i,
    input  logic                         pred_taken_i,
    input  logic [31:0]                  pred_target_i,
    output logic                         pred_ready_o,
    input  logic [31:0]                  lookup_pc_i,
    output logic                         lookup_taken_o,
    input  logic                         res_valid_i,
    input  logic                         res_is_branch_i,
    input  logic                         res_taken_i,
    input  logic [31:0]                  res_target_i,
    output logic                         mispredict_o,
    output logic [31:0]                  redirect_pc_o,
    output logic                         res_error_o,
    output logic [$clog2(QUEUE_DEPTH):0] occupancy_o
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [OCC_W-1:0] OCC_ONE = 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(QUEUE_DEPTH);

    pred_entry_t      queue_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0] occ_q;
    logic             mispredict_q, res_error_q;
    logic [31:0]      redirect_q;

    pred_entry_t head, new_entry;
    logic [31:0] head_seq_pc, actual_pc, predicted_pc;
    logic        full, empty, push, resolve, mismatch, pop;
    cnt_t        lookup_cnt;

    assign full  = (occ_q == OCC_FULL);
    assign empty = (occ_q == '0);

    // Refuse pushes while redirecting: anything fetch sends then is wrong-path.
    assign pred_ready_o = !full && !mispredict_q;
    assign push         = pred_valid_i && pred_ready_o;

    assign new_entry = '{pc: pred_pc_i, taken: pred_taken_i, target: pred_target_i};

    assign head         = queue_mem[rd_ptr_q];
    assign head_seq_pc  = head.pc + 32'd4;
    assign actual_pc    = res_taken_i ? res_target_i : head_seq_pc;
    assign predicted_pc = head.taken  ? head.target  : head_seq_pc;

    assign resolve  = res_valid_i && !empty;
    assign mismatch = resolve && (actual_pc != predicted_pc);
    assign pop      = resolve && !mismatch;

    // Queue payload: validity is carried by occ_q, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push && !mismatch) begin
            queue_mem[wr_ptr_q] <= new_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            res_error_q  <= 1'b0;
        end else begin
            mispredict_q <= mismatch;
            if (mismatch) begin
                // Flush: same-cycle push is wrong-path and is dropped too.
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                occ_q      <= '0;
                redirect_q <= actual_pc;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
                if (push && !pop) begin
                    occ_q <= occ_q + OCC_ONE;
                end else if (!push && pop) begin
                    occ_q <= occ_q - OCC_ONE;
                end
            end
            if (res_valid_i && empty) begin
                res_error_q <= 1'b1;
            end
        end
    end

    pht #(
        .PHT_BITS (PHT_BITS),
        .RESET_CNT(RESET_CNT)
    ) u_pht (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rd_idx_i   (lookup_pc_i[PHT_BITS+1:2]),
        .rd_cnt_o   (lookup_cnt),
        .upd_en_i   (resolve && res_is_branch_i),
        .upd_idx_i  (head.pc[PHT_BITS+1:2]),
        .upd_taken_i(res_taken_i)
    );

    // Only the counter's direction bit drives the prediction.
    assign lookup_taken_o = lookup_cnt[1];

    logic unused_ok;
    assign unused_ok = ^{lookup_cnt[0], lookup_pc_i[31:PHT_BITS+2], lookup_pc_i[1:0]};

    assign mispredict_o  = mispredict_q;
    assign redirect_pc_o = redirect_q;
    assign res_error_o   = res_error_q;
    assign occupancy_o   = occ_q;

endmodule

// File: tb/tb_branch_resolver.sv
module tb_branch_resolver;
    import bp_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        pred_valid_i = 1'b0;
    logic [31:0] pred_pc_i = '0;
    logic        pred_taken_i = 1'b0;
    logic [31:0] pred_target_i = '0;
    logic        pred_ready_o;
    logic [31:0] lookup_pc_i = '0;
    logic        lookup_taken_o;
    logic        res_valid_i = 1'b0;
    logic        res_is_branch_i = 1'b0;
    logic        res_taken_i = 1'b0;
    logic [31:0] res_target_i = '0;
    logic        mispredict_o;
    logic [31:0] redirect_pc_o;
    logic        res_error_o;
    logic [2:0]  occupancy_o;

    always #5 clk_i = ~clk_i;

    branch_resolver dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .pred_valid_i   (pred_valid_i),
        .pred_pc_i      (pred_pc_i),
        .pred_taken_i   (pred_taken_i),
        .pred_target_i  (pred_target_i),
        .pred_ready_o   (pred_ready_o),
        .lookup_pc_i    (lookup_pc_i),
        .lookup_taken_o (lookup_taken_o),
        .res_valid_i    (res_valid_i),
        .res_is_branch_i(res_is_branch_i),
        .res_taken_i    (res_taken_i),
        .res_target_i   (res_target_i),
        .mispredict_o   (mispredict_o),
        .redirect_pc_o  (redirect_pc_o),
        .res_error_o    (res_error_o),
        .occupancy_o    (occupancy_o)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    pred_entry_t m_q[$];
    int          m_pht[64];
    bit          m_mis;
    logic [31:0] m_redir;
    bit          m_err;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_q.delete();
            foreach (m_pht[i]) m_pht[i] = 1;
            m_mis   = 0;
            m_redir = '0;
            m_err   = 0;
        end else begin : model_step
            bit          accept, mis;
            pred_entry_t h, e;
            logic [31:0] act, prd;
            int          idx;
            accept = (m_q.size() < 4) && !m_mis && pred_valid_i;
            mis    = 0;
            if (res_valid_i) begin
                if (m_q.size() == 0) begin
                    m_err = 1;
                end else begin
                    h   = m_q[0];
                    act = res_taken_i ? res_target_i : h.pc + 32'd4;
                    prd = h.taken ? h.target : h.pc + 32'd4;
                    if (res_is_branch_i) begin
                        idx = int'((h.pc >> 2) % 64);
                        if (res_taken_i) m_pht[idx] = (m_pht[idx] >= 3) ? 3 : m_pht[idx] + 1;
                        else             m_pht[idx] = (m_pht[idx] <= 0) ? 0 : m_pht[idx] - 1;
                    end
                    if (act != prd) begin
                        mis     = 1;
                        m_redir = act;
                        m_q.delete();
                        accept  = 0;
                    end else begin
                        void'(m_q.pop_front());
                    end
                end
            end
            if (accept) begin
                e.pc     = pred_pc_i;
                e.taken  = pred_taken_i;
                e.target = pred_target_i;
                m_q.push_back(e);
            end
            m_mis = mis;
        end
    end

    // Compare process: every cycle out of reset, on the inactive edge.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            check("occupancy", 32'(occupancy_o), 32'(m_q.size()));
            check("pred_ready", 32'(pred_ready_o), 32'((m_q.size() < 4) && !m_mis));
            check("mispredict", 32'(mispredict_o), 32'(m_mis));
            check("redirect_pc", redirect_pc_o, m_redir);
            check("res_error", 32'(res_error_o), 32'(m_err));
            check("lookup_taken", 32'(lookup_taken_o),
                  32'(m_pht[int'((lookup_pc_i >> 2) % 64)] >= 2));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
        pred_valid_i  = 1'b1;
        pred_pc_i     = pc;
        pred_taken_i  = tk;
        pred_target_i = tg;
    endtask

    task automatic drive_res(input logic br, input logic tk, input logic [31:0] tg);
        res_valid_i     = 1'b1;
        res_is_branch_i = br;
        res_taken_i     = tk;
        res_target_i    = tg;
    endtask

    task automatic step();
        @(posedge clk_i);
        #2;
        pred_valid_i = 1'b0;
        res_valid_i  = 1'b0;
        #1;
    endtask

    task automatic look(input logic [31:0] pc);
        lookup_pc_i = pc;
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #2 rst_ni = 1'b1;
        #1;

        // 1. reset state
        look(32'h100);
        check("rst_lookup_100", 32'(lookup_taken_o), 0);
        check("rst_ready", 32'(pred_ready_o), 1);
        check("rst_occupancy", 32'(occupancy_o), 0);
        check("rst_error", 32'(res_error_o), 0);
        check("rst_mispredict", 32'(mispredict_o), 0);
        check("rst_redirect", redirect_pc_o, 0);

        // 2. correct not-taken branch; counter 01 -> 00 (then 00 -> 01 stays not-taken)
        drive_push(32'h100, 1'b0, 32'h0); step();
        check("t2_occ_after_push", 32'(occupancy_o), 1);
        drive_res(1'b1, 1'b0, 32'h0); step();
        check("t2_no_mispredict", 32'(mispredict_o), 0);
        check("t2_occ_after_pop", 32'(occupancy_o), 0);
        drive_push(32'h100, 1'b0, 32'h0); step();
        drive_res(1'b1, 1'b1, 32'h104); step();
        check("t2_fallthrough_match", 32'(mispredict_o), 0);
        look(32'h100);
        check("t2_pht0_decremented", 32'(lookup_taken_o), 0);

        // 3. fill, then oldest resolves taken to 0x180 against not-taken prediction
        drive_push(32'h204, 1'b0, 32'h0); step();
        drive_push(32'h208, 1'b0, 32'h0); step();
        drive_push(32'h20c, 1'b0, 32'h0); step();
        drive_push(32'h210, 1'b0, 32'h0); step();
        check("t3_occ_full", 32'(occupancy_o), 4);
        check("t3_ready_full", 32'(pred_ready_o), 0);
        drive_res(1'b1, 1'b1, 32'h180); step();
        check("t3_mispredict", 32'(mispredict_o), 1);
        check("t3_redirect", redirect_pc_o, 32'h180);
        check("t3_flushed", 32'(occupancy_o), 0);
        check("t3_ready_during_redirect", 32'(pred_ready_o), 0);
        step();
        check("t3_pulse_ends", 32'(mispredict_o), 0);
        check("t3_redirect_holds", redirect_pc_o, 32'h180);
        look(32'h204);
        check("t3_lookup_204", 32'(lookup_taken_o), 1);

        // 4. full queue refuses push despite same-cycle pop; push on mismatch dropped
        drive_push(32'h500, 1'b0, 32'h0); step();
        drive_push(32'h504, 1'b0, 32'h0); step();
        drive_push(32'h508, 1'b0, 32'h0); step();
        drive_push(32'h50c, 1'b0, 32'h0); step();
        check("t4_ready_full", 32'(pred_ready_o), 0);
        drive_push(32'h600, 1'b0, 32'h0);
        drive_res(1'b1, 1'b0, 32'h0); step();
        check("t4_push_refused", 32'(occupancy_o), 3);
        drive_push(32'h700, 1'b0, 32'h0);
        drive_res(1'b1, 1'b1, 32'h900); step();
        check("t4_mispredict", 32'(mispredict_o), 1);
        check("t4_redirect", redirect_pc_o, 32'h900);
        check("t4_push_dropped", 32'(occupancy_o), 0);
        step();

        // 5. saturation at 0x300 (index 0 is at 00 here), then jump must not train
        lookup_pc_i = 32'h300;
        for (int i = 0; i < 4; i++) begin
            drive_push(32'h300, 1'b1, 32'h380); step();
            drive_res(1'b1, 1'b1, 32'h380); step();
            check("t5_taken_match", 32'(mispredict_o), 0);
        end
        check("t5_saturated_taken", 32'(lookup_taken_o), 1);
        drive_push(32'h300, 1'b0, 32'h0); step();
        drive_res(1'b1, 1'b0, 32'h0); step();
        check("t5_11_to_10_still_taken", 32'(lookup_taken_o), 1);
        drive_push(32'h400, 1'b1, 32'h500); step();
        drive_res(1'b0, 1'b1, 32'h500); step();
        check("t5_jump_match", 32'(mispredict_o), 0);
        drive_push(32'h300, 1'b0, 32'h0); step();
        drive_res(1'b1, 1'b0, 32'h0); step();
        check("t5_jump_did_not_train", 32'(lookup_taken_o), 0);

        // 6. resolve on empty queue, then async reset mid-fill
        drive_res(1'b1, 1'b1, 32'h1234); step();
        check("t6_error_set", 32'(res_error_o), 1);
        check("t6_error_no_mispredict", 32'(mispredict_o), 0);
        step();
        check("t6_error_sticky", 32'(res_error_o), 1);
        drive_push(32'h300, 1'b0, 32'h0); step();
        drive_res(1'b1, 1'b1, 32'h380); step();
        check("t6_mispredict", 32'(mispredict_o), 1);
        check("t6_lookup_trained", 32'(lookup_taken_o), 1);
        step();
        drive_push(32'h300, 1'b0, 32'h0); step();
        drive_push(32'h304, 1'b0, 32'h0); step();
        check("t6_occ_before_reset", 32'(occupancy_o), 2);
        drive_push(32'h308, 1'b0, 32'h0);
        #1 rst_ni = 1'b0;
        #1;
        check("t6_async_occ", 32'(occupancy_o), 0);
        check("t6_async_error", 32'(res_error_o), 0);
        check("t6_async_mispredict", 32'(mispredict_o), 0);
        check("t6_async_redirect", redirect_pc_o, 0);
        check("t6_async_ready", 32'(pred_ready_o), 1);
        check("t6_async_pht", 32'(lookup_taken_o), 0);
        pred_valid_i = 1'b0;
        #3 rst_ni = 1'b1;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
